bitty_sequencer: RTL and testbench

//  Parametrised fetch/decode/execute controller for the bitty core. Drives instruction fetch over
//  a req/ack handshake, holds the instruction register and PC, pulses the executor, and steers the

---
 rtl/bitty_seq_if.sv | 23 ++
 rtl/bitty_sequencer.sv | 135 +++++++++++++
 tb/tb_bitty_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bitty_seq_if.sv
// Fetch and execute handshake bundle between the bitty sequencer and its memory/executor.
interface bitty_seq_if #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16
);
  logic                   fetch_req;
  logic [PC_WIDTH-1:0]    fetch_addr;
  logic                   fetch_ack;
  logic [INSTR_WIDTH-1:0] fetch_instr;
  logic [PC_WIDTH-1:0]    branch_pc;
  logic                   exec_run;
  logic                   exec_done;

  modport master (
    output fetch_req, fetch_addr, exec_run,
    input  fetch_ack, fetch_instr, branch_pc, exec_done
  );

  modport slave (
    input  fetch_req, fetch_addr, exec_run,
    output fetch_ack, fetch_instr, branch_pc, exec_done
  );
endinterface

// File: rtl/bitty_sequencer.sv
// Fetch/decode/execute controller for the bitty core with single-step, halt requests,
// fetch/execute watchdog and a retired-instruction counter.
module bitty_sequencer #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned OPC_LSB     = 0,
  parameter logic [1:0]  IO_OPCODE   = 2'b11,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   step_mode,
  input  logic                   halt_req,
  bitty_seq_if.master            bus,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   uart_sel,
  output logic                   busy,
  output logic                   halted,
  output logic                   timeout_err,
  output logic [CNT_WIDTH-1:0]   instr_count
);

  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_PC_UPD, S_EXEC, S_WAIT, S_HALT, S_ERR
  } state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   io_q, io_d;
  logic                   err_q, err_d;
  logic                   halt_q, halt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      io_q    <= 1'b0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      io_q    <= io_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
    end
  end

  // Watchdog only advances while staying in FETCH or WAIT; every other path leaves it at zero.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wd_d    = '0;
    io_d    = io_q;
    err_d   = err_q;
    halt_d  = halt_q | halt_req;
    case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (start) begin
          state_d = S_FETCH;
          err_d   = 1'b0;
          if (state_q != S_HALT) halt_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (bus.fetch_ack) begin
          instr_d = bus.fetch_instr;
          state_d = S_DECODE;
        end else if (wd_q == WD_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_DECODE: begin
        io_d    = (instr_q[OPC_LSB +: 2] == IO_OPCODE);
        state_d = S_PC_UPD;
      end
      S_PC_UPD: begin
        pc_d    = bus.branch_pc;
        state_d = S_EXEC;
      end
      S_EXEC: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.exec_done) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (step_mode || halt_d) begin
            state_d = S_HALT;
            halt_d  = 1'b0;
          end else begin
            state_d = S_FETCH;
            err_d   = 1'b0;
          end
        end else if (wd_q == WD_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from flops only, so reset clears them without waiting for a clock.
  assign bus.fetch_req  = (state_q == S_FETCH);
  assign bus.fetch_addr = pc_q;
  assign bus.exec_run   = (state_q == S_EXEC);
  assign uart_sel       = io_q && ((state_q == S_EXEC) || (state_q == S_WAIT));
  assign busy           = !((state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERR));
  assign halted         = (state_q == S_HALT);
  assign timeout_err    = err_q;
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign instr_count    = cnt_q;

endmodule

// File: tb/tb_bitty_sequencer.sv
// Directed plus randomized bench for bitty_sequencer against an instruction-level reference model.
module tb_bitty_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, step_mode, halt_req;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic        uart_sel, busy, halted, timeout_err;
  logic [15:0] instr_count;

  logic        start2;
  logic [15:0] instr2;
  logic [7:0]  pc2;
  logic        uart_sel2, busy2, halted2, timeout_err2;
  logic [3:0]  cnt2;

  int checks = 0;
  int errors = 0;

  // Reference model state: architectural view of one retired instruction at a time.
  logic [7:0]  m_pc;
  logic [15:0] m_count;
  bit          m_halt;

  always #5 clk = ~clk;

  bitty_seq_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus ();
  bitty_seq_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus2 ();

  bitty_sequencer #(
    .PC_WIDTH(8), .INSTR_WIDTH(16), .OPC_LSB(0), .IO_OPCODE(2'b11),
    .TIMEOUT(16), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start), .step_mode(step_mode), .halt_req(halt_req),
    .bus(bus), .instr(instr), .pc(pc), .uart_sel(uart_sel), .busy(busy), .halted(halted),
    .timeout_err(timeout_err), .instr_count(instr_count)
  );

  // Narrow-counter instance with a zero-latency memory/executor to reach counter wrap quickly.
  bitty_sequencer #(
    .PC_WIDTH(8), .INSTR_WIDTH(16), .OPC_LSB(0), .IO_OPCODE(2'b11),
    .TIMEOUT(16), .CNT_WIDTH(4)
  ) dut2 (
    .clk(clk), .reset(rst_n), .start(start2), .step_mode(1'b0), .halt_req(1'b0),
    .bus(bus2), .instr(instr2), .pc(pc2), .uart_sel(uart_sel2), .busy(busy2), .halted(halted2),
    .timeout_err(timeout_err2), .instr_count(cnt2)
  );

  assign bus2.fetch_ack   = bus2.fetch_req;
  assign bus2.exec_done   = 1'b1;
  assign bus2.branch_pc   = bus2.fetch_addr + 8'd1;
  assign bus2.fetch_instr = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resume();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("resume_fetch_req", 32'(bus.fetch_req), 32'd1);
    chk("resume_busy", 32'(busy), 32'd1);
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_timeout_err", 32'(timeout_err), 32'd0);
    chk("resume_fetch_addr", 32'(bus.fetch_addr), 32'(m_pc));
  endtask

  // Runs one instruction from the FETCH state; done_dly is the WAIT cycle index carrying exec_done.
  task automatic run_instr(input logic [15:0] ins, input logic [7:0] bpc, input int ack_dly,
                           input int done_dly, input bit halt_pulse);
    bit io;
    bit go_halt;
    io = (ins[1:0] == 2'b11);
    chk("fetch_req", 32'(bus.fetch_req), 32'd1);
    chk("fetch_addr", 32'(bus.fetch_addr), 32'(m_pc));
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      chk("fetch_hold", 32'(bus.fetch_req), 32'd1);
    end
    bus.fetch_ack   = 1'b1;
    bus.fetch_instr = ins;
    bus.branch_pc   = bpc;
    tick();
    bus.fetch_ack   = 1'b0;
    bus.fetch_instr = 16'($urandom);
    chk("decode_fetch_req", 32'(bus.fetch_req), 32'd0);
    chk("instr", 32'(instr), 32'(ins));
    chk("decode_exec_run", 32'(bus.exec_run), 32'd0);
    tick();
    chk("pcupd_exec_run", 32'(bus.exec_run), 32'd0);
    tick();
    chk("exec_run", 32'(bus.exec_run), 32'd1);
    chk("exec_pc", 32'(pc), 32'(bpc));
    chk("exec_uart_sel", 32'(uart_sel), 32'(io));
    bus.branch_pc = 8'($urandom);
    tick();
    chk("wait_exec_run", 32'(bus.exec_run), 32'd0);
    chk("wait_uart_sel", 32'(uart_sel), 32'(io));
    for (int i = 0; i < done_dly; i++) begin
      if (halt_pulse && i == 0) begin
        halt_req = 1'b1;
        m_halt   = 1'b1;
      end
      tick();
      halt_req = 1'b0;
    end
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    m_count = m_count + 16'd1;
    m_pc    = bpc;
    go_halt = step_mode || m_halt;
    if (go_halt) m_halt = 1'b0;
    chk("instr_count", 32'(instr_count), 32'(m_count));
    chk("retire_halted", 32'(halted), 32'(go_halt));
    chk("retire_fetch_req", 32'(bus.fetch_req), 32'(!go_halt));
    chk("retire_busy", 32'(busy), 32'(!go_halt));
    chk("retire_uart_sel", 32'(uart_sel), 32'd0);
    chk("retire_exec_run", 32'(bus.exec_run), 32'd0);
    if (!go_halt) chk("next_fetch_addr", 32'(bus.fetch_addr), 32'(m_pc));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; step_mode = 1'b0; halt_req = 1'b0; start2 = 1'b0;
    bus.fetch_ack = 1'b0; bus.fetch_instr = '0; bus.branch_pc = '0; bus.exec_done = 1'b0;
    m_pc = '0; m_count = '0; m_halt = 1'b0;
    tick();
    tick();
    chk("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
    chk("rst_exec_run", 32'(bus.exec_run), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_uart_sel", 32'(uart_sel), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_instr_count", 32'(instr_count), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic I/O instruction, then a zero-wait instruction exercising the start-to-exec_run latency.
    resume();
    run_instr(16'h0003, 8'h05, 1, 2, 1'b0);
    run_instr(16'h1234, 8'h09, 0, 0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      run_instr(16'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 5)), 1'b0);
    end

    // Single-step halts after retirement, then start resumes.
    step_mode = 1'b1;
    run_instr(16'h0001, 8'h21, 0, 1, 1'b0);
    step_mode = 1'b0;
    tick();
    tick();
    chk("step_stays_halted", 32'(halted), 32'd1);
    chk("step_no_fetch", 32'(bus.fetch_req), 32'd0);
    resume();

    // Halt request during WAIT lets the instruction retire, then halts.
    run_instr(16'h0102, 8'h33, 2, 3, 1'b1);
    tick();
    tick();
    chk("halt_stays_halted", 32'(halted), 32'd1);
    chk("halt_no_fetch", 32'(bus.fetch_req), 32'd0);
    resume();

    // No fetch_ack: ERR exactly TIMEOUT cycles after entering FETCH.
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("to_still_fetching", 32'(bus.fetch_req), 32'd1);
    end
    chk("to_err_before", 32'(timeout_err), 32'd0);
    tick();
    chk("to_fetch_req", 32'(bus.fetch_req), 32'd0);
    chk("to_timeout_err", 32'(timeout_err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_uart_sel", 32'(uart_sel), 32'd0);
    tick();
    chk("to_sticky", 32'(timeout_err), 32'd1);
    resume();

    // Ack and exec_done both on the last watchdog cycle: both win over expiry.
    run_instr(16'h00F3, 8'h40, 15, 15, 1'b0);
    chk("tie_timeout_err", 32'(timeout_err), 32'd0);

    // Asynchronous reset while WAIT holds the UART for an I/O instruction.
    bus.fetch_ack = 1'b1; bus.fetch_instr = 16'h0007; bus.branch_pc = 8'h77;
    tick();
    bus.fetch_ack = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_uart_sel", 32'(uart_sel), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_uart_sel", 32'(uart_sel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_fetch_req", 32'(bus.fetch_req), 32'd0);
    chk("mid_rst_exec_run", 32'(bus.exec_run), 32'd0);
    chk("mid_rst_instr_count", 32'(instr_count), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_instr", 32'(instr), 32'd0);
    m_pc = '0; m_count = '0; m_halt = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Retire counter wraps to zero on the narrow instance.
    start2 = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      int n;
      n = 0;
      while (!bus2.exec_run && n < 10) begin
        tick();
        n++;
      end
      chk("wrap_exec_run_seen", 32'(bus2.exec_run), 32'd1);
      tick();
      tick();
      chk("wrap_count", 32'(cnt2), 32'(k % 16));
      chk("wrap_pc", 32'(pc2), 32'(k % 256));
    end
    start2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
